// File: rtl/instr_encoder_pkg.sv
// Shared constants for the MIPS-I instruction encoder: opsel codes, opcode/func tables,
// FSM state type and word-packing helpers.
package instr_encoder_pkg;

  typedef enum logic [1:0] {StIdle, StWrite, StFull, StDone} state_e;

  // Instruction kind codes presented on in_opsel; 36..63 are illegal.
  localparam logic [5:0] OpselAddu  = 6'd0;
  localparam logic [5:0] OpselSubu  = 6'd1;
  localparam logic [5:0] OpselSlt   = 6'd2;
  localparam logic [5:0] OpselAnd   = 6'd3;
  localparam logic [5:0] OpselNor   = 6'd4;
  localparam logic [5:0] OpselOr    = 6'd5;
  localparam logic [5:0] OpselXor   = 6'd6;
  localparam logic [5:0] OpselSll   = 6'd7;
  localparam logic [5:0] OpselSrl   = 6'd8;
  localparam logic [5:0] OpselSltu  = 6'd9;
  localparam logic [5:0] OpselJalr  = 6'd10;
  localparam logic [5:0] OpselJr    = 6'd11;
  localparam logic [5:0] OpselSllv  = 6'd12;
  localparam logic [5:0] OpselSra   = 6'd13;
  localparam logic [5:0] OpselSrav  = 6'd14;
  localparam logic [5:0] OpselSrlv  = 6'd15;
  localparam logic [5:0] OpselAddiu = 6'd16;
  localparam logic [5:0] OpselLw    = 6'd17;
  localparam logic [5:0] OpselSw    = 6'd18;
  localparam logic [5:0] OpselLui   = 6'd19;
  localparam logic [5:0] OpselSlti  = 6'd20;
  localparam logic [5:0] OpselSltiu = 6'd21;
  localparam logic [5:0] OpselLb    = 6'd22;
  localparam logic [5:0] OpselLbu   = 6'd23;
  localparam logic [5:0] OpselSb    = 6'd24;
  localparam logic [5:0] OpselAndi  = 6'd25;
  localparam logic [5:0] OpselOri   = 6'd26;
  localparam logic [5:0] OpselXori  = 6'd27;
  localparam logic [5:0] OpselBeq   = 6'd28;
  localparam logic [5:0] OpselBne   = 6'd29;
  localparam logic [5:0] OpselBgez  = 6'd30;
  localparam logic [5:0] OpselBgtz  = 6'd31;
  localparam logic [5:0] OpselBlez  = 6'd32;
  localparam logic [5:0] OpselBltz  = 6'd33;
  localparam logic [5:0] OpselJ     = 6'd34;
  localparam logic [5:0] OpselJal   = 6'd35;

  // Primary opcodes
  localparam logic [5:0] OpSpecial = 6'h00;
  localparam logic [5:0] OpRegimm  = 6'h01;
  localparam logic [5:0] OpJ       = 6'h02;
  localparam logic [5:0] OpJal     = 6'h03;
  localparam logic [5:0] OpBeq     = 6'h04;
  localparam logic [5:0] OpBne     = 6'h05;
  localparam logic [5:0] OpBlez    = 6'h06;
  localparam logic [5:0] OpBgtz    = 6'h07;
  localparam logic [5:0] OpAddiu   = 6'h09;
  localparam logic [5:0] OpSlti    = 6'h0a;
  localparam logic [5:0] OpSltiu   = 6'h0b;
  localparam logic [5:0] OpAndi    = 6'h0c;
  localparam logic [5:0] OpOri     = 6'h0d;
  localparam logic [5:0] OpXori    = 6'h0e;
  localparam logic [5:0] OpLui     = 6'h0f;
  localparam logic [5:0] OpLb      = 6'h20;
  localparam logic [5:0] OpLw      = 6'h23;
  localparam logic [5:0] OpLbu     = 6'h24;
  localparam logic [5:0] OpSb      = 6'h28;
  localparam logic [5:0] OpSw      = 6'h2b;

  // SPECIAL func codes
  localparam logic [5:0] FnSll  = 6'h00;
  localparam logic [5:0] FnSrl  = 6'h02;
  localparam logic [5:0] FnSra  = 6'h03;
  localparam logic [5:0] FnSllv = 6'h04;
  localparam logic [5:0] FnSrlv = 6'h06;
  localparam logic [5:0] FnSrav = 6'h07;
  localparam logic [5:0] FnJr   = 6'h08;
  localparam logic [5:0] FnJalr = 6'h09;
  localparam logic [5:0] FnAddu = 6'h21;
  localparam logic [5:0] FnSubu = 6'h23;
  localparam logic [5:0] FnAnd  = 6'h24;
  localparam logic [5:0] FnOr   = 6'h25;
  localparam logic [5:0] FnXor  = 6'h26;
  localparam logic [5:0] FnNor  = 6'h27;
  localparam logic [5:0] FnSlt  = 6'h2a;
  localparam logic [5:0] FnSltu = 6'h2b;

  // REGIMM selects bgez/bltz through the rt field.
  localparam logic [4:0] RtBgez = 5'd1;
  localparam logic [4:0] RtBltz = 5'd0;

  function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sh,
                                         input logic [5:0] fn);
    return {OpSpecial, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] j_word(input logic [5:0] op, input logic [25:0] tgt);
    return {op, tgt};
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Request channel and instruction-memory write port of the encoder.
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_opsel;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic [4:0]  in_shamt;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        imem_ready;

  // master: request source plus memory model; slave: the encoder itself.
  modport master (
    output in_valid, in_opsel, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target, imem_ready,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_opsel, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target, imem_ready,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/instr_field_pack.sv
// Combinational map from opsel plus operand fields to a 32-bit MIPS-I word and a legal flag.
module instr_field_pack
  import instr_encoder_pkg::*;
(
  input  logic [5:0]  opsel_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  shamt_i,
  input  logic [15:0] imm_i,
  input  logic [25:0] target_i,
  output logic [31:0] word_o,
  output logic        legal_o
);

  always_comb begin
    word_o  = '0;
    legal_o = 1'b1;
    case (opsel_i)
      OpselAddu:  word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FnAddu);
      OpselSubu:  word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FnSubu);
      OpselSlt:   word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FnSlt);
      OpselAnd:   word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FnAnd);
      OpselNor:   word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FnNor);
      OpselOr:    word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FnOr);
      OpselXor:   word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FnXor);
      OpselSll:   word_o = r_word(rs_i, rt_i, rd_i, shamt_i, FnSll);
      OpselSrl:   word_o = r_word(rs_i, rt_i, rd_i, shamt_i, FnSrl);
      OpselSltu:  word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FnSltu);
      OpselJalr:  word_o = r_word(rs_i, 5'd0, rd_i, 5'd0, FnJalr);
      OpselJr:    word_o = r_word(rs_i, 5'd0, 5'd0, 5'd0, FnJr);
      OpselSllv:  word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FnSllv);
      OpselSra:   word_o = r_word(rs_i, rt_i, rd_i, shamt_i, FnSra);
      OpselSrav:  word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FnSrav);
      OpselSrlv:  word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FnSrlv);
      OpselAddiu: word_o = i_word(OpAddiu, rs_i, rt_i, imm_i);
      OpselLw:    word_o = i_word(OpLw, rs_i, rt_i, imm_i);
      OpselSw:    word_o = i_word(OpSw, rs_i, rt_i, imm_i);
      OpselLui:   word_o = i_word(OpLui, 5'd0, rt_i, imm_i);
      OpselSlti:  word_o = i_word(OpSlti, rs_i, rt_i, imm_i);
      OpselSltiu: word_o = i_word(OpSltiu, rs_i, rt_i, imm_i);
      OpselLb:    word_o = i_word(OpLb, rs_i, rt_i, imm_i);
      OpselLbu:   word_o = i_word(OpLbu, rs_i, rt_i, imm_i);
      OpselSb:    word_o = i_word(OpSb, rs_i, rt_i, imm_i);
      OpselAndi:  word_o = i_word(OpAndi, rs_i, rt_i, imm_i);
      OpselOri:   word_o = i_word(OpOri, rs_i, rt_i, imm_i);
      OpselXori:  word_o = i_word(OpXori, rs_i, rt_i, imm_i);
      OpselBeq:   word_o = i_word(OpBeq, rs_i, rt_i, imm_i);
      OpselBne:   word_o = i_word(OpBne, rs_i, rt_i, imm_i);
      OpselBgez:  word_o = i_word(OpRegimm, rs_i, RtBgez, imm_i);
      OpselBgtz:  word_o = i_word(OpBgtz, rs_i, 5'd0, imm_i);
      OpselBlez:  word_o = i_word(OpBlez, rs_i, 5'd0, imm_i);
      OpselBltz:  word_o = i_word(OpRegimm, rs_i, RtBltz, imm_i);
      OpselJ:     word_o = j_word(OpJ, target_i);
      OpselJal:   word_o = j_word(OpJal, target_i);
      default:    legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Encodes instruction requests and streams them into instruction memory, one word per
// handshake, starting at BASE_ADDR and stopping after DEPTH words.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
  parameter int unsigned DEPTH     = 1024
) (
  input  logic            clk,
  input  logic            rst,
  instr_encoder_if.slave  bus,
  input  logic            finish,
  output logic [10:0]     count,
  output logic            full,
  output logic            done,
  output logic            err
);

  localparam logic [11:0] DepthW = 12'(DEPTH);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [10:0] count_q, count_d;
  logic        err_q, err_d;

  logic [31:0] word;
  logic        legal;
  logic [11:0] count_inc;

  instr_field_pack u_pack (
    .opsel_i  (bus.in_opsel),
    .rs_i     (bus.in_rs),
    .rt_i     (bus.in_rt),
    .rd_i     (bus.in_rd),
    .shamt_i  (bus.in_shamt),
    .imm_i    (bus.in_imm),
    .target_i (bus.in_target),
    .word_o   (word),
    .legal_o  (legal)
  );

  assign count_inc = {1'b0, count_q} + 12'd1;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    count_d = count_q;
    err_d   = err_q;
    case (state_q)
      StIdle: begin
        // A pending request takes priority over finish; finish is seen on a later idle cycle.
        if (bus.in_valid) begin
          if (legal) begin
            wdata_d = word;
            state_d = StWrite;
          end else begin
            err_d = 1'b1;
          end
        end else if (finish) begin
          state_d = StDone;
        end
      end
      StWrite: begin
        if (bus.imem_ready) begin
          addr_d  = addr_q + 32'd4;
          count_d = count_inc[10:0];
          state_d = (count_inc == DepthW) ? StFull : StIdle;
        end
      end
      StFull: begin
        if (finish) state_d = StDone;
      end
      StDone:  state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= BASE_ADDR;
      wdata_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Decoded straight from state so reset drops the write strobe without waiting for a clock.
  assign bus.in_ready   = (state_q == StIdle);
  assign bus.imem_we    = (state_q == StWrite);
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign count          = count_q;
  assign full           = (state_q == StFull);
  assign done           = (state_q == StDone);
  assign err            = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: a default-depth instance and a DEPTH=2 instance.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        finish, finish_s;
  logic [10:0] count, count_s;
  logic        full, done, err, full_s, done_s, err_s;

  instr_encoder_if bus ();
  instr_encoder_if bus_s ();

  instr_encoder dut (
    .clk(clk), .rst(rst), .bus(bus), .finish(finish),
    .count(count), .full(full), .done(done), .err(err)
  );

  instr_encoder #(.DEPTH(2)) dut_s (
    .clk(clk), .rst(rst), .bus(bus_s), .finish(finish_s),
    .count(count_s), .full(full_s), .done(done_s), .err(err_s)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          wr_cnt = 0;
  int          wr_cnt_s = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp_s[$];
  logic [63:0] e_m, e_s;
  logic [31:0] exp_addr, exp_addr_s;
  logic [10:0] exp_count;

  // Independent MIPS-I reference encoding.
  function automatic logic [31:0] model(input int sel, input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [15:0] imm, input logic [25:0] tg);
    case (sel)
      0:  return {6'h00, rs, rt, rd, 5'd0, 6'h21};
      1:  return {6'h00, rs, rt, rd, 5'd0, 6'h23};
      2:  return {6'h00, rs, rt, rd, 5'd0, 6'h2a};
      3:  return {6'h00, rs, rt, rd, 5'd0, 6'h24};
      4:  return {6'h00, rs, rt, rd, 5'd0, 6'h27};
      5:  return {6'h00, rs, rt, rd, 5'd0, 6'h25};
      6:  return {6'h00, rs, rt, rd, 5'd0, 6'h26};
      7:  return {6'h00, rs, rt, rd, sh, 6'h00};
      8:  return {6'h00, rs, rt, rd, sh, 6'h02};
      9:  return {6'h00, rs, rt, rd, 5'd0, 6'h2b};
      10: return {6'h00, rs, 5'd0, rd, 5'd0, 6'h09};
      11: return {6'h00, rs, 5'd0, 5'd0, 5'd0, 6'h08};
      12: return {6'h00, rs, rt, rd, 5'd0, 6'h04};
      13: return {6'h00, rs, rt, rd, sh, 6'h03};
      14: return {6'h00, rs, rt, rd, 5'd0, 6'h07};
      15: return {6'h00, rs, rt, rd, 5'd0, 6'h06};
      16: return {6'h09, rs, rt, imm};
      17: return {6'h23, rs, rt, imm};
      18: return {6'h2b, rs, rt, imm};
      19: return {6'h0f, 5'd0, rt, imm};
      20: return {6'h0a, rs, rt, imm};
      21: return {6'h0b, rs, rt, imm};
      22: return {6'h20, rs, rt, imm};
      23: return {6'h24, rs, rt, imm};
      24: return {6'h28, rs, rt, imm};
      25: return {6'h0c, rs, rt, imm};
      26: return {6'h0d, rs, rt, imm};
      27: return {6'h0e, rs, rt, imm};
      28: return {6'h04, rs, rt, imm};
      29: return {6'h05, rs, rt, imm};
      30: return {6'h01, rs, 5'd1, imm};
      31: return {6'h07, rs, 5'd0, imm};
      32: return {6'h06, rs, 5'd0, imm};
      33: return {6'h01, rs, 5'd0, imm};
      34: return {6'h02, tg};
      35: return {6'h03, tg};
      default: return 32'h0;
    endcase
  endfunction

  // Scoreboard monitors: every committed write is popped against the expected queue.
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1 && bus.imem_ready === 1'b1) begin
      wr_cnt++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL main_write unexpected addr=%h data=%h required none",
                 bus.imem_addr, bus.imem_wdata);
      end else begin
        e_m = exp_q.pop_front();
        if ({bus.imem_addr, bus.imem_wdata} !== e_m) begin
          n_err++;
          $display("FAIL main_write addr=%h data=%h required addr=%h data=%h",
                   bus.imem_addr, bus.imem_wdata, e_m[63:32], e_m[31:0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (bus_s.imem_we === 1'b1 && bus_s.imem_ready === 1'b1) begin
      wr_cnt_s++;
      n_cmp++;
      if (exp_s.size() == 0) begin
        n_err++;
        $display("FAIL small_write unexpected addr=%h data=%h required none",
                 bus_s.imem_addr, bus_s.imem_wdata);
      end else begin
        e_s = exp_s.pop_front();
        if ({bus_s.imem_addr, bus_s.imem_wdata} !== e_s) begin
          n_err++;
          $display("FAIL small_write addr=%h data=%h required addr=%h data=%h",
                   bus_s.imem_addr, bus_s.imem_wdata, e_s[63:32], e_s[31:0]);
        end
      end
    end
  end

  task automatic issue(input logic [5:0] sel, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                       input logic [25:0] tg, input logic [31:0] word, input bit push);
    int t = 0;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) begin
      n_cmp++; n_err++;
      $display("FAIL issue_timeout in_ready=%b required 1", bus.in_ready);
    end
    bus.in_opsel = sel; bus.in_rs = rs; bus.in_rt = rt; bus.in_rd = rd;
    bus.in_shamt = sh; bus.in_imm = imm; bus.in_target = tg; bus.in_valid = 1'b1;
    if (push) begin exp_q.push_back({exp_addr, word}); exp_addr += 32'd4; end
    @(posedge clk); #1 bus.in_valid = 1'b0;
  endtask

  task automatic issue_s(input logic [5:0] sel, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [15:0] imm, input logic [31:0] word, input bit push);
    int t = 0;
    @(negedge clk);
    while (bus_s.in_ready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) begin
      n_cmp++; n_err++;
      $display("FAIL issue_s_timeout in_ready=%b required 1", bus_s.in_ready);
    end
    bus_s.in_opsel = sel; bus_s.in_rs = rs; bus_s.in_rt = rt; bus_s.in_rd = 5'd0;
    bus_s.in_shamt = 5'd0; bus_s.in_imm = imm; bus_s.in_target = '0; bus_s.in_valid = 1'b1;
    if (push) begin exp_s.push_back({exp_addr_s, word}); exp_addr_s += 32'd4; end
    @(posedge clk); #1 bus_s.in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; finish = 1'b0; finish_s = 1'b0;
    bus.in_valid = 1'b0; bus.in_opsel = '0; bus.in_rs = '0; bus.in_rt = '0; bus.in_rd = '0;
    bus.in_shamt = '0; bus.in_imm = '0; bus.in_target = '0; bus.imem_ready = 1'b1;
    bus_s.in_valid = 1'b0; bus_s.in_opsel = '0; bus_s.in_rs = '0; bus_s.in_rt = '0;
    bus_s.in_rd = '0; bus_s.in_shamt = '0; bus_s.in_imm = '0; bus_s.in_target = '0;
    bus_s.imem_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b required 1", bus.in_ready); end
    n_cmp++; if (bus.imem_we !== 1'b0) begin n_err++; $display("FAIL reset_we got %b required 0", bus.imem_we); end
    n_cmp++; if (bus.imem_addr !== 32'h3000) begin n_err++; $display("FAIL reset_addr got %h required 00003000", bus.imem_addr); end
    n_cmp++; if (bus.imem_wdata !== 32'h0) begin n_err++; $display("FAIL reset_wdata got %h required 0", bus.imem_wdata); end
    n_cmp++; if (count !== 11'd0) begin n_err++; $display("FAIL reset_count got %0d required 0", count); end
    n_cmp++; if ({full, done, err} !== 3'b000) begin n_err++; $display("FAIL reset_flags got %b required 000", {full, done, err}); end
    @(posedge clk); #1 rst = 1'b0;
    exp_addr = 32'h3000; exp_addr_s = 32'h3000; exp_count = '0;
  endtask

  task automatic test_addu;
    issue(6'd0, 5'd1, 5'd2, 5'd3, 5'd5, 16'h0, 26'h0, 32'h00221821, 1'b1);
    exp_count++;
    @(negedge clk);
    n_cmp++; if (bus.imem_we !== 1'b1) begin n_err++; $display("FAIL addu_latency we got %b required 1", bus.imem_we); end
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL addu_busy in_ready got %b required 0", bus.in_ready); end
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL addu_drain pending %0d required 0", exp_q.size()); end
    @(posedge clk); #1; @(negedge clk);
    n_cmp++; if (count !== exp_count) begin n_err++; $display("FAIL addu_count got %0d required %0d", count, exp_count); end
    n_cmp++; if (bus.imem_addr !== 32'h3004) begin n_err++; $display("FAIL addu_addr got %h required 00003004", bus.imem_addr); end
  endtask

  task automatic test_lw_j;
    issue(6'd17, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0004, 26'h0, 32'h8FA80004, 1'b1);
    issue(6'd34, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0100000, 32'h08100000, 1'b1);
    exp_count += 11'd2;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL lw_j_drain pending %0d required 0", exp_q.size()); end
  endtask

  task automatic test_bgez_stall;
    @(posedge clk); #1 bus.imem_ready = 1'b0;
    issue(6'd30, 5'd4, 5'd7, 5'd0, 5'd0, 16'hFFFF, 26'h0, 32'h0481FFFF, 1'b1);
    exp_count++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++; if (bus.imem_we !== 1'b1) begin n_err++; $display("FAIL stall_we cyc%0d got %b required 1", i, bus.imem_we); end
      n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready cyc%0d got %b required 0", i, bus.in_ready); end
      n_cmp++; if (bus.imem_addr !== 32'h300C) begin n_err++; $display("FAIL stall_addr cyc%0d got %h required 0000300c", i, bus.imem_addr); end
      n_cmp++; if (bus.imem_wdata !== 32'h0481FFFF) begin n_err++; $display("FAIL stall_wdata cyc%0d got %h required 0481ffff", i, bus.imem_wdata); end
      if (i == 2) begin @(posedge clk); #1 bus.imem_ready = 1'b1; end
    end
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL stall_drain pending %0d required 0", exp_q.size()); end
    @(posedge clk); #1; @(negedge clk);
    n_cmp++; if (count !== exp_count) begin n_err++; $display("FAIL stall_count got %0d required %0d", count, exp_count); end
  endtask

  task automatic test_illegal;
    logic [5:0] bad [3];
    int w0;
    bad[0] = 6'd36; bad[1] = 6'd40; bad[2] = 6'd63;
    for (int k = 0; k < 3; k++) begin
      w0 = wr_cnt;
      issue(bad[k], 5'd1, 5'd1, 5'd1, 5'd1, 16'h1, 26'h1, 32'h0, 1'b0);
      repeat (2) @(negedge clk);
      n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL illegal_err op%0d got %b required 1", bad[k], err); end
      n_cmp++; if (wr_cnt != w0) begin n_err++; $display("FAIL illegal_nowrite op%0d writes %0d required %0d", bad[k], wr_cnt, w0); end
      n_cmp++; if (count !== exp_count) begin n_err++; $display("FAIL illegal_count op%0d got %0d required %0d", bad[k], count, exp_count); end
      n_cmp++; if (bus.imem_addr !== exp_addr) begin n_err++; $display("FAIL illegal_addr op%0d got %h required %h", bad[k], bus.imem_addr, exp_addr); end
      n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL illegal_idle op%0d in_ready got %b required 1", bad[k], bus.in_ready); end
    end
    issue(6'd16, 5'd2, 5'd3, 5'd0, 5'd0, 16'h8000, 26'h0, 32'h24438000, 1'b1);
    exp_count++;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL illegal_next_drain pending %0d required 0", exp_q.size()); end
    n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL illegal_sticky got %b required 1", err); end
  endtask

  task automatic test_all_opsel;
    logic [4:0]  a, b, c, d;
    logic [15:0] im;
    logic [25:0] tg;
    for (int s = 0; s < 36; s++) begin
      a = 5'($urandom); b = 5'($urandom); c = 5'($urandom); d = 5'($urandom);
      im = 16'($urandom); tg = 26'($urandom);
      issue(6'(s), a, b, c, d, im, tg, model(s, a, b, c, d, im, tg), 1'b1);
    end
    exp_count += 11'd36;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL all_opsel_drain pending %0d required 0", exp_q.size()); end
    @(posedge clk); #1; @(negedge clk);
    n_cmp++; if (count !== exp_count) begin n_err++; $display("FAIL all_opsel_count got %0d required %0d", count, exp_count); end
  endtask

  task automatic test_finish;
    @(posedge clk); #1 bus.imem_ready = 1'b0;
    @(negedge clk);
    bus.in_opsel = 6'd0; bus.in_rs = 5'd7; bus.in_rt = 5'd8; bus.in_rd = 5'd9;
    bus.in_shamt = 5'd0; bus.in_valid = 1'b1; finish = 1'b1;
    exp_q.push_back({exp_addr, model(0, 5'd7, 5'd8, 5'd9, 5'd0, 16'h0, 26'h0)});
    exp_addr += 32'd4; exp_count++;
    @(posedge clk); #1 bus.in_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      n_cmp++; if (bus.imem_we !== 1'b1) begin n_err++; $display("FAIL finish_write_we got %b required 1", bus.imem_we); end
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL finish_in_write_done got %b required 0", done); end
    end
    @(posedge clk); #1 bus.imem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (bus.in_ready !== 1'b1 || done !== 1'b0) begin n_err++; $display("FAIL finish_idle_first ready/done got %b%b required 10", bus.in_ready, done); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL finish_done got %b required 1", done); end
    n_cmp++; if (bus.in_ready !== 1'b0 || bus.imem_we !== 1'b0) begin n_err++; $display("FAIL finish_done_outputs ready/we got %b%b required 00", bus.in_ready, bus.imem_we); end
    finish = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL done_sticky got %b required 1", done); end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL finish_drain pending %0d required 0", exp_q.size()); end
    n_cmp++; if (count !== exp_count) begin n_err++; $display("FAIL finish_count got %0d required %0d", count, exp_count); end
  endtask

  task automatic test_depth_full;
    issue_s(6'd16, 5'd1, 5'd2, 16'h0011, 32'h24220011, 1'b1);
    issue_s(6'd26, 5'd3, 5'd4, 16'h00FF, 32'h346400FF, 1'b1);
    bus_s.in_opsel = 6'd0; bus_s.in_valid = 1'b1;
    repeat (5) @(negedge clk);
    n_cmp++; if (bus_s.in_ready !== 1'b0) begin n_err++; $display("FAIL depth_in_ready got %b required 0", bus_s.in_ready); end
    n_cmp++; if (full_s !== 1'b1) begin n_err++; $display("FAIL depth_full got %b required 1", full_s); end
    n_cmp++; if (count_s !== 11'd2) begin n_err++; $display("FAIL depth_count got %0d required 2", count_s); end
    n_cmp++; if (wr_cnt_s != 2) begin n_err++; $display("FAIL depth_writes got %0d required 2", wr_cnt_s); end
    bus_s.in_valid = 1'b0; finish_s = 1'b1;
    @(posedge clk); #1; @(negedge clk);
    n_cmp++; if ({done_s, full_s} !== 2'b10) begin n_err++; $display("FAIL depth_done done/full got %b required 10", {done_s, full_s}); end
    finish_s = 1'b0;
  endtask

  task automatic test_reset_mid_write;
    int w0;
    rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
    exp_addr_s = 32'h3000;
    bus_s.imem_ready = 1'b0;
    issue_s(6'd0, 5'd1, 5'd2, 16'h0, 32'h0, 1'b0);
    @(negedge clk);
    n_cmp++; if (bus_s.imem_we !== 1'b1) begin n_err++; $display("FAIL midwrite_we_before got %b required 1", bus_s.imem_we); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (bus_s.imem_we !== 1'b0) begin n_err++; $display("FAIL midwrite_we_drop got %b required 0", bus_s.imem_we); end
    n_cmp++; if (count_s !== 11'd0 || bus_s.imem_addr !== 32'h3000) begin n_err++; $display("FAIL midwrite_state count=%0d addr=%h required 0/00003000", count_s, bus_s.imem_addr); end
    w0 = wr_cnt_s;
    @(posedge clk); #1 rst = 1'b0; bus_s.imem_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (wr_cnt_s != w0 || bus_s.in_ready !== 1'b1) begin n_err++; $display("FAIL midwrite_discard writes=%0d ready=%b required %0d/1", wr_cnt_s, bus_s.in_ready, w0); end
  endtask

  initial begin
    test_reset();
    test_addu();
    test_lw_j();
    test_bgez_stall();
    test_illegal();
    test_all_opsel();
    test_finish();
    test_depth_full();
    test_reset_mid_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_3000, byte address of the first instruction word written.
REQ-002 Parameter DEPTH, default 1024, maximum number of words written before the block stops accepting.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  an instruction request is present.
REQ-006 in_ready  output  1  the block accepts a request this cycle.
REQ-007 in_opsel  input  6  instruction kind code (REQ-014).
REQ-008 in_rs, in_rt, in_rd, in_shamt  input  5 each  register and shift fields.
REQ-009 in_imm  input  16  immediate; in_target  input  26  jump target field.
REQ-010 finish  input  1  level request to close the program.
REQ-011 imem_we  output  1; imem_addr  output  32; imem_wdata  output  32  instruction-memory write port.
REQ-012 imem_ready  input  1  memory accepts the write on this edge.
REQ-013 count  output  11  words written; full, done, err  output  1 each.

Function
REQ-014 opsel codes: 0 addu, 1 subu, 2 slt, 3 and, 4 nor, 5 or, 6 xor, 7 sll, 8 srl, 9 sltu, 10 jalr, 11 jr, 12 sllv, 13 sra, 14 srav, 15 srlv, 16 addiu, 17 lw, 18 sw, 19 lui, 20 slti, 21 sltiu, 22 lb, 23 lbu, 24 sb, 25 andi, 26 ori, 27 xori, 28 beq, 29 bne, 30 bgez, 31 bgtz, 32 blez, 33 bltz, 34 j, 35 jal; 36-63 illegal.
REQ-015 R-type word = {6'b000000, rs, rt, rd, shamt, func}; shamt forced to 0 except sll/srl/sra; jr forces rt=rd=0; jalr forces rt=0.
REQ-016 I-type word = {op, rs, rt, imm}; lui forces rs=0; bgez forces rt=1; bltz, bgtz, blez force rt=0.
REQ-017 J-type word = {op, target}.
REQ-018 op/func values are the standard MIPS-I values (e.g. addu func 100001, lw op 100011, bgez/bltz op 000001, j op 000010).
REQ-019 States: IDLE, WRITE, FULL, DONE.
REQ-020 IDLE: in_ready=1; handshake (in_valid & in_ready) at an edge with legal opsel registers imem_wdata and moves to WRITE.
REQ-021 WRITE: in_ready=0, imem_we=1, imem_addr and imem_wdata held stable until an edge with imem_ready=1.
REQ-022 On that edge: imem_addr += 4, count += 1; next state FULL if new count == DEPTH, else IDLE.
REQ-023 Throughput: at most one word per two cycles; write appears one cycle after handshake.
REQ-024 Illegal opsel: request accepted, err set sticky, no write, address/count unchanged, stay in IDLE.
REQ-025 finish in IDLE with in_valid=0 -> DONE; in_valid=1 with finish: request handled first, finish honoured on a later IDLE cycle.
REQ-026 finish in WRITE is ignored until back in IDLE.
REQ-027 FULL: in_ready=0, full=1; finish -> DONE; otherwise hold.
REQ-028 DONE: in_ready=0, imem_we=0, done=1; exit only by reset.
REQ-029 imem_we is 0 in every state except WRITE.

Reset
REQ-030 rst asynchronously forces IDLE, imem_addr=BASE_ADDR, imem_wdata=0, imem_we=0, count=0, full=0, done=0, err=0.
REQ-031 Reset during WRITE drops imem_we immediately; the pending word is discarded.

Structure
REQ-032 Shared package holds opsel constants, the op and func constant tables, and the state typedef.
REQ-033 One combinational sub-module, instr_field_pack, maps opsel plus fields to the 32-bit word and a legal flag.

Verification
REQ-034 addu rs=1 rt=2 rd=3 shamt=5, imem_ready=1 -> imem_wdata 0x00221821 at 0x00003000, count=1.
REQ-035 lw rs=29 rt=8 imm=0x0004 then j target=0x0100000 -> 0x8FA80004 at 0x3000, 0x08100000 at 0x3004.
REQ-036 bgez rs=4 rt=7 imm=0xFFFF with imem_ready low 3 cycles -> 0x0481FFFF held 4 cycles, in_ready=0 throughout.
REQ-037 opsel=40 -> err=1, no imem_we pulse, count unchanged; next legal request written at 0x3000.
REQ-038 DEPTH=2, three requests -> two writes, full=1, in_ready=0; finish -> done=1; rst mid-WRITE -> imem_we=0 at once, count=0.
